// File: rtl/prog_mem_reader.sv
// Instruction-memory readback engine: owns the address mux, holds the CPU in reset,
// walks [first_addr..last_addr] (wrapping) and streams each word on a valid/ready port.
module prog_mem_reader #(
    parameter int ADDR_WIDTH   = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] first_addr,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    output logic                  mem_enable,
    output logic                  cpu_hold,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   word_count
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_OUT, S_DONE} state_t;

    // A zero-latency memory still needs one READ cycle to register its data.
    localparam int         RL_EFF    = (READ_LATENCY < 1) ? 1 : READ_LATENCY;
    localparam logic [1:0] WAIT_LAST = 2'(RL_EFF - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] last_q, last_d;
    logic [1:0]            wait_q, wait_d;
    logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q      <= '0;
            last_q     <= '0;
            wait_q     <= '0;
            out_addr_q <= '0;
            out_data_q <= '0;
            count_q    <= '0;
        end else begin
            ptr_q      <= ptr_d;
            last_q     <= last_d;
            wait_q     <= wait_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_READ;
            S_READ: begin
                if (abort)                    state_d = S_IDLE;
                else if (wait_q == WAIT_LAST) state_d = S_OUT;
            end
            S_OUT: begin
                if (abort)                state_d = S_IDLE;
                else if (out_ready)       state_d = (ptr_q == last_q) ? S_DONE : S_READ;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ptr_d      = ptr_q;
        last_d     = last_q;
        wait_d     = wait_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        count_d    = count_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ptr_d   = first_addr;
                    last_d  = last_addr;
                    wait_d  = '0;
                    count_d = '0;
                end
            end
            S_READ: begin
                // mem_rdata is only looked at here, so X elsewhere never reaches out_data.
                if (wait_q == WAIT_LAST) begin
                    out_data_d = mem_rdata;
                    out_addr_d = ptr_q;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    count_d = count_q + (ADDR_WIDTH+1)'(1);
                    if (ptr_q != last_q) begin
                        ptr_d  = ptr_q + ADDR_WIDTH'(1);
                        wait_d = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy       = (state_q != S_IDLE);
        mem_enable = busy;
        cpu_hold   = busy;
        mem_addr   = (state_q == S_READ) ? ptr_q : '0;
        out_valid  = (state_q == S_OUT);
        done       = (state_q == S_DONE) && !abort;
        out_addr   = out_addr_q;
        out_data   = out_data_q;
        word_count = count_q;
    end

endmodule

// File: tb/tb_prog_mem_reader.sv
// Directed bench: latency-1 instance with async-read memory, latency-2 instance with
// a one-register-stage memory; both read the same 16-word image.
module tb_prog_mem_reader;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] mem [16];

    // Instance A: READ_LATENCY=1
    logic       start_a = 1'b0, abort_a = 1'b0, out_ready_a = 1'b1;
    logic [3:0] first_a = '0, last_a = '0;
    logic       mem_enable_a, cpu_hold_a, out_valid_a, busy_a, done_a;
    logic [3:0] mem_addr_a, out_addr_a;
    logic [7:0] mem_rdata_a, out_data_a;
    logic [4:0] word_count_a;
    assign mem_rdata_a = mem[mem_addr_a];

    prog_mem_reader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .READ_LATENCY(1)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .abort(abort_a),
        .first_addr(first_a), .last_addr(last_a),
        .mem_enable(mem_enable_a), .cpu_hold(cpu_hold_a), .mem_addr(mem_addr_a),
        .mem_rdata(mem_rdata_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_addr(out_addr_a), .out_data(out_data_a), .busy(busy_a), .done(done_a),
        .word_count(word_count_a)
    );

    // Instance B: READ_LATENCY=2, memory with a registered address stage
    logic       start_b = 1'b0, abort_b = 1'b0, out_ready_b = 1'b1;
    logic [3:0] first_b = '0, last_b = '0;
    logic       mem_enable_b, cpu_hold_b, out_valid_b, busy_b, done_b;
    logic [3:0] mem_addr_b, out_addr_b, addr_b_d1;
    logic [7:0] mem_rdata_b, out_data_b;
    logic [4:0] word_count_b;
    always_ff @(posedge clk) addr_b_d1 <= mem_addr_b;
    assign mem_rdata_b = mem[addr_b_d1];

    prog_mem_reader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .READ_LATENCY(2)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .abort(abort_b),
        .first_addr(first_b), .last_addr(last_b),
        .mem_enable(mem_enable_b), .cpu_hold(cpu_hold_b), .mem_addr(mem_addr_b),
        .mem_rdata(mem_rdata_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_addr(out_addr_b), .out_data(out_data_b), .busy(busy_b), .done(done_b),
        .word_count(word_count_b)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Walk on instance A. stall_beat: beat index held off for 7 cycles (-1 none);
    // abort_beat: abort in the READ of that beat (-1 none); spur: pulse start while busy.
    task automatic walk_a(input logic [3:0] f, input logic [3:0] l, input int exp_words,
                          input int stall_beat, input int abort_beat, input bit spur);
        int         beats = 0;
        int         stall = 0;
        logic [3:0] ea = f;
        logic [7:0] held_d = '0;
        bit         got_done = 1'b0;
        bit         acc_prev = 1'b0;
        @(negedge clk);
        first_a = f; last_a = l; start_a = 1'b1; out_ready_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check_eq("busy_after_start", busy_a, 1);
        check_eq("mem_enable_after_start", mem_enable_a, 1);
        for (int c = 0; c < 400; c++) begin
            if (spur && c == 1) begin
                start_a = 1'b1; first_a = ~f; last_a = ~l;
            end else if (spur && c == 2) begin
                start_a = 1'b0;
            end
            if (abort_beat >= 0 && beats == abort_beat && busy_a && !out_valid_a) begin
                abort_a = 1'b1;
                @(negedge clk);
                abort_a = 1'b0;
                check_eq("abort_busy", busy_a, 0);
                check_eq("abort_valid", out_valid_a, 0);
                check_eq("abort_mem_enable", mem_enable_a, 0);
                check_eq("abort_cpu_hold", cpu_hold_a, 0);
                check_eq("abort_done", done_a, 0);
                check_eq("abort_word_count", word_count_a, abort_beat);
                $display("[TB] walk %0d..%0d aborted after %0d words", f, l, beats);
                return;
            end
            acc_prev = 1'b0;
            if (out_valid_a) begin
                if (beats == stall_beat && stall < 7) begin
                    out_ready_a = 1'b0;
                    if (stall == 0) held_d = out_data_a;
                    check_eq("stall_addr", out_addr_a, ea);
                    check_eq("stall_data", out_data_a, held_d);
                    stall++;
                end else begin
                    out_ready_a = 1'b1;
                    check_eq("beat_addr", out_addr_a, ea);
                    check_eq("beat_data", out_data_a, mem[ea]);
                    beats++;
                    ea = ea + 4'd1;
                    acc_prev = 1'b1;
                end
            end
            @(negedge clk);
            out_ready_a = 1'b1;
            if (done_a) begin
                got_done = 1'b1;
                break;
            end
            if (busy_a) check_eq("cpu_hold_during_walk", cpu_hold_a, 1);
        end
        check_eq("done_seen", got_done, 1);
        check_eq("done_after_last_beat", acc_prev, 1);
        check_eq("done_mem_enable", mem_enable_a, 1);
        check_eq("beats", beats, exp_words);
        check_eq("word_count", word_count_a, exp_words);
        @(negedge clk);
        check_eq("done_one_cycle", done_a, 0);
        check_eq("idle_busy", busy_a, 0);
        check_eq("idle_mem_enable", mem_enable_a, 0);
        check_eq("idle_cpu_hold", cpu_hold_a, 0);
        $display("[TB] walk %0d..%0d words %0d", f, l, beats);
    endtask

    initial begin
        mem[0]  = 8'h1F; mem[1]  = 8'h20; mem[2]  = 8'h31; mem[3]  = 8'h42;
        mem[4]  = 8'h5E; mem[5]  = 8'h60; mem[6]  = 8'h71; mem[7]  = 8'h82;
        mem[8]  = 8'h9A; mem[9]  = 8'hA3; mem[10] = 8'hB0; mem[11] = 8'hC1;
        mem[12] = 8'hD4; mem[13] = 8'hE5; mem[14] = 8'hF6; mem[15] = 8'h07;

        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", busy_a, 0);
        check_eq("rst_mem_enable", mem_enable_a, 0);
        check_eq("rst_out_valid", out_valid_a, 0);
        check_eq("rst_word_count", word_count_a, 0);
        check_eq("rst_out_data", out_data_a, 0);
        reset_n = 1'b1;

        walk_a(4'd0,  4'd11, 12, -1, -1, 1'b0);
        walk_a(4'd14, 4'd1,  4,  -1, -1, 1'b0);
        walk_a(4'd5,  4'd5,  1,  -1, -1, 1'b0);
        walk_a(4'd0,  4'd11, 12, 3,  -1, 1'b0);
        walk_a(4'd0,  4'd11, 12, -1, 6,  1'b0);
        walk_a(4'd0,  4'd11, 12, -1, -1, 1'b0);
        walk_a(4'd2,  4'd4,  3,  -1, -1, 1'b1);

        // Latency-2 full-range walk on instance B
        begin
            int         beats = 0;
            int         gap = 0;
            logic [3:0] ea = 4'd0;
            bit         got_done = 1'b0;
            @(negedge clk);
            first_b = 4'd0; last_b = 4'd15; start_b = 1'b1;
            @(negedge clk);
            start_b = 1'b0;
            for (int c = 0; c < 400; c++) begin
                if (out_valid_b) begin
                    check_eq("b_read_cycles", gap, 2);
                    check_eq("b_beat_addr", out_addr_b, ea);
                    check_eq("b_beat_data", out_data_b, mem[ea]);
                    gap = 0;
                    beats++;
                    ea = ea + 4'd1;
                end else if (busy_b) begin
                    gap++;
                end
                @(negedge clk);
                if (done_b) begin
                    got_done = 1'b1;
                    break;
                end
            end
            check_eq("b_done_seen", got_done, 1);
            check_eq("b_beats", beats, 16);
            check_eq("b_word_count", word_count_b, 5'b10000);
            $display("[TB] walk B 0..15 words %0d", beats);
        end

        // Asynchronous reset while in OUT
        begin
            bit in_out = 1'b0;
            @(negedge clk);
            first_a = 4'd0; last_a = 4'd11; start_a = 1'b1; out_ready_a = 1'b0;
            @(negedge clk);
            start_a = 1'b0;
            for (int c = 0; c < 20; c++) begin
                if (out_valid_a) begin
                    in_out = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            check_eq("reach_out_before_reset", in_out, 1);
            #2 reset_n = 1'b0;
            #1;
            check_eq("async_rst_mem_enable", mem_enable_a, 0);
            check_eq("async_rst_cpu_hold", cpu_hold_a, 0);
            check_eq("async_rst_out_valid", out_valid_a, 0);
            check_eq("async_rst_busy", busy_a, 0);
            check_eq("async_rst_done", done_a, 0);
            check_eq("async_rst_out_addr", out_addr_a, 0);
            check_eq("async_rst_out_data", out_data_a, 0);
            check_eq("async_rst_word_count", word_count_a, 0);
            @(negedge clk);
            check_eq("rst_no_done", done_a, 0);
            reset_n = 1'b1;
            out_ready_a = 1'b1;
            $display("[TB] async reset mid-OUT");
        end

        walk_a(4'd9, 4'd10, 2, -1, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
